instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
- Front-end stage sitting directly upstream of the control unit.
- Owns the 8-bit program counter and the memory address register (MAR).
- Reads a 3-byte instruction (opcode, operand A, operand B) from byte-wide synchronous program memory.
- Assembles and holds the 24-bit command_word, raises ReadyRegFlag when it is valid, and responds to the control unit's MAR_load / PC_inc / PC_en / IR_load strobes.

Parameters:
- ADDR_W, 8, program-memory address and PC width.
- DATA_W, 8, program-memory data width (one instruction byte).
- PC_STEP, 3, PC increment per PC_inc (bytes per instruction).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- MAR_load  in  1  fetch request: latch PC into MAR and start a 3-byte read.
- PC_inc  in  1  advance PC by PC_STEP.
- PC_en  in  1  absolute PC load enable.
- PC_load  in  8  absolute PC value, used when PC_en=1.
- IR_load  in  1  consume strobe: commit the staged word to command_word.
- mem_rdata  in  8  program-memory read data; valid the cycle after mem_rd_en.
- mem_addr  out  8  program-memory address.
- mem_rd_en  out  1  program-memory read enable.
- command_word  out  24  instruction register: [23:16] opcode, [15:8] op A, [7:0] op B.
- ReadyRegFlag  out  1  staged instruction complete and not yet consumed.
- PC_current_value  out  8  current PC.
- fetch_busy  out  1  read sequence in progress.

Behaviour:
- Reset (rst high at a clock edge) sets PC=0, MAR=0, staging=0, command_word=0, ReadyRegFlag=0, state=IDLE. This also applies mid-fetch: the fetch is abandoned and no partial word is kept.
- In IDLE and READY, mem_rd_en=0 and mem_addr=MAR.
- PC update, evaluated every cycle with priority rst > PC_en > PC_inc:
  - PC_en=1: PC <= PC_load.
  - Else PC_inc=1: PC <= (PC+PC_STEP) mod 256.
  - PC is independent of the fetch FSM. A PC change during a fetch does not disturb it, because the fetch uses the latched MAR.
- FSM states: IDLE, ISSUE0, ISSUE1, ISSUE2, LAST, READY.
  - IDLE: if MAR_load, MAR <= PC and go to ISSUE0.
  - ISSUE0: mem_rd_en=1, mem_addr=MAR; go to ISSUE1.
  - ISSUE1: mem_rd_en=1, mem_addr=MAR+1; capture mem_rdata into staging[23:16]; go to ISSUE2.
  - ISSUE2: mem_rd_en=1, mem_addr=MAR+2; capture staging[15:8]; go to LAST.
  - LAST: mem_rd_en=0; capture staging[7:0]; go to READY.
  - READY: ReadyRegFlag=1. If IR_load, command_word <= staging and go to IDLE, so ReadyRegFlag is low the next cycle.
- Latency: ReadyRegFlag is high 4 clock cycles after the edge that samples MAR_load in IDLE. The committed word appears on command_word 1 cycle after the IR_load edge in READY.
- MAR_load while not in IDLE (busy or READY) is ignored; there is no queueing.
- IR_load while not in READY is ignored, and command_word holds its value.
- MAR_load and IR_load in the same READY cycle: commit only, go to IDLE. The request is dropped; the control unit re-issues it.
- Address arithmetic is mod 256: MAR=8'hFE reads FE, FF, 00.
- fetch_busy=1 in ISSUE0..LAST, 0 otherwise.
- command_word changes only on a commit or on reset.

Decomposition:
- Shared package contains:
  - fetch state encodings (localparams, 3-bit);
  - ADDR_W / DATA_W / PC_STEP constants;
  - instruction field slices: opcode [23:16], op A [15:8], op B [7:0]. The control unit uses the same slices.
- One sub-module, program_counter, is natural: PC register with rst/PC_en/PC_inc priority and mod-256 add.

Test Plan:
- Fetch: memory[10..12]=03,01,02, PC=10, pulse MAR_load -> reads at 10,11,12 on consecutive cycles. ReadyRegFlag rises 4 cycles after the MAR_load edge. IR_load then gives command_word=24'h030102 and ReadyRegFlag=0 next cycle.
- Wrap-around: PC_en with PC_load=FE, MAR_load -> mem_addr FE, FF, 00. PC_inc at PC=FE -> PC=01.
- PC priority: PC_en=1 with PC_load=40 and PC_inc=1 in the same cycle -> PC=40. PC_inc alone from 40 -> 43.
- Ignored strobes: MAR_load during ISSUE1 -> no restart, MAR unchanged. IR_load in IDLE -> command_word unchanged.
- PC change mid-fetch: MAR_load at PC=20, then PC_en with PC_load=80 during ISSUE0 -> bytes still read from 20..22, PC=80.
- Reset mid-fetch: rst during ISSUE2 -> next cycle state IDLE, PC=0, ReadyRegFlag=0, command_word=0, mem_rd_en=0.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared widths, fetch state encodings and instruction field slices
// Contents:
//   ADDR_W / DATA_W / PC_STEP  address width, byte width, PC advance per instruction
//   IW                         instruction word width (three bytes)
//   fetch_state_t              3-bit fetch FSM encodings
//   OPC_LSB / OPA_LSB / OPB_LSB field offsets; the control unit decodes with the same slices
package instruction_fetch_unit_pkg;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int PC_STEP = 3;
    localparam int IW      = 3 * DATA_W;
    localparam int OPC_LSB = 16;
    localparam int OPA_LSB = 8;
    localparam int OPB_LSB = 0;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE0 = 3'd1,
        ISSUE1 = 3'd2,
        ISSUE2 = 3'd3,
        LAST   = 3'd4,
        READY  = 3'd5
    } fetch_state_t;
endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// program_counter: PC register with absolute load taking priority over the mod-256 increment
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   en, load  absolute PC load
//   inc       advance PC by PC_STEP
//   pc        current PC
module program_counter
    import instruction_fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load,
    output logic [ADDR_W-1:0] pc
);
    always_ff @(posedge clk)
        if (rst)      pc <= '0;
        else if (en)  pc <= load;
        else if (inc) pc <= pc + ADDR_W'(PC_STEP);
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches a 3-byte instruction from synchronous byte memory into command_word
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   MAR_load                 latch PC into MAR and start a read (only honoured in IDLE)
//   PC_inc, PC_en, PC_load   PC advance / absolute load (load wins)
//   IR_load                  commit staged word to command_word (only honoured in READY)
//   mem_rdata                memory data, valid the cycle after mem_rd_en
//   mem_addr, mem_rd_en      memory request
//   command_word             instruction register {opcode, op A, op B}
//   ReadyRegFlag             staged word complete and not yet consumed
//   PC_current_value         current PC
//   fetch_busy               read sequence in flight
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              MAR_load,
    input  logic              PC_inc,
    input  logic              PC_en,
    input  logic [ADDR_W-1:0] PC_load,
    input  logic              IR_load,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic [IW-1:0]     command_word,
    output logic              ReadyRegFlag,
    output logic [ADDR_W-1:0] PC_current_value,
    output logic              fetch_busy
);
    fetch_state_t      state, state_nx;
    logic [ADDR_W-1:0] mar;
    logic [IW-1:0]     staging;

    program_counter u_pc (
        .clk  (clk),
        .rst  (rst),
        .en   (PC_en),
        .inc  (PC_inc),
        .load (PC_load),
        .pc   (PC_current_value)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = MAR_load ? ISSUE0 : IDLE;
            ISSUE0:  state_nx = ISSUE1;
            ISSUE1:  state_nx = ISSUE2;
            ISSUE2:  state_nx = LAST;
            LAST:    state_nx = READY;
            READY:   state_nx = IR_load ? IDLE : READY;
            default: state_nx = IDLE;
        endcase
    end

    // Each ISSUE state presents the next byte address; data for the previous issue arrives alongside.
    assign mem_rd_en    = state == ISSUE0 || state == ISSUE1 || state == ISSUE2;
    assign mem_addr     = mar + (state == ISSUE1 ? ADDR_W'(1) : state == ISSUE2 ? ADDR_W'(2) : ADDR_W'(0));
    assign fetch_busy   = mem_rd_en || state == LAST;
    assign ReadyRegFlag = state == READY;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mar          <= '0;
            staging      <= '0;
            command_word <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && MAR_load) mar <= PC_current_value;
            if (state == ISSUE1) staging[OPC_LSB +: DATA_W] <= mem_rdata;
            if (state == ISSUE2) staging[OPA_LSB +: DATA_W] <= mem_rdata;
            if (state == LAST)   staging[OPB_LSB +: DATA_W] <= mem_rdata;
            if (state == READY && IR_load) command_word <= staging;
        end
    end
endmodule
